mc_control_fsm: RTL and testbench

Registered multi-cycle control sequencer for the 32-bit multi-cycle CPU datapath (PC, shared instruction/data cache, IR, register file, X/Y/Z registers, ALU). It walks each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select and strobe from the current state plus the IR op/fn fields. It also inserts wait states on a memory-ready handshake and resolves conditional branches from ALU flags.

---
 rtl/mc_control_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control sequencer.
// Walks fetch/decode/execute/memory/writeback and drives datapath controls.
module mc_control_fsm #(
  parameter logic       SYSCALL_SEL = 1'b0,
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic       alu_zero,
  input  logic       x_sign,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       InstData,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] RegInSrc,
  output logic       ALUSrcX,
  output logic [1:0] ALUSrcY,
  output logic [1:0] FunctionClass,
  output logic [1:0] LogFunc,
  output logic       AddSub,
  output logic [1:0] PCSrc,
  output logic       JumpAddr,
  output logic [3:0] state,
  output logic       instr_done
);

  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_DEC   = 4'd1;
  localparam logic [3:0] S_MADDR = 4'd2;
  localparam logic [3:0] S_MRD   = 4'd3;
  localparam logic [3:0] S_MWB   = 4'd4;
  localparam logic [3:0] S_BR    = 4'd5;
  localparam logic [3:0] S_MWR   = 4'd6;
  localparam logic [3:0] S_AEX   = 4'd7;
  localparam logic [3:0] S_AWB   = 4'd8;
  localparam logic [3:0] S_JMP   = 4'd9;
  localparam logic [3:0] S_JR    = 4'd10;
  localparam logic [3:0] S_TRAP  = 4'd11;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       r_type;
  logic       taken;

  assign state  = state_q;
  assign r_type = (op == 6'h00);

  // Branch condition from ALU flags, selected by the branch opcode.
  always_comb begin
    taken = 1'b0;
    case (op)
      6'h04:   taken = alu_zero;
      6'h05:   taken = ~alu_zero;
      6'h01:   taken = x_sign;
      default: taken = 1'b0;
    endcase
  end

  // Instruction class lookup performed in DECODE.
  function automatic logic [3:0] dec_target(input logic [5:0] o,
                                            input logic [5:0] f);
    logic [3:0] t;
    t = S_TRAP;
    case (o)
      6'h23, 6'h2B: t = S_MADDR;
      6'h04, 6'h05, 6'h01: t = S_BR;
      6'h02, 6'h03: t = S_JMP;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: t = S_AEX;
      6'h00: begin
        case (f)
          6'h08: t = S_JR;
          6'h20, 6'h22, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A: t = S_AEX;
          default: t = S_TRAP;
        endcase
      end
      default: t = S_TRAP;
    endcase
    return t;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Next-state selection; memory states wait on mem_ready.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = mem_ready ? S_DEC : S_FETCH;
      S_DEC:   state_d = dec_target(op, fn);
      S_MADDR: state_d = (op == 6'h23) ? S_MRD : S_MWR;
      S_MRD:   state_d = mem_ready ? S_MWB : S_MRD;
      S_MWR:   state_d = mem_ready ? S_FETCH : S_MWR;
      S_AEX:   state_d = S_AWB;
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath controls from state and IR fields; all zero during reset.
  always_comb begin
    PCWrite       = 1'b0;
    InstData      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 2'd0;
    RegInSrc      = 2'd0;
    ALUSrcX       = 1'b0;
    ALUSrcY       = 2'd0;
    FunctionClass = 2'd0;
    LogFunc       = 2'd0;
    AddSub        = 1'b0;
    PCSrc         = 2'd0;
    JumpAddr      = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead       = 1'b1;
          FunctionClass = 2'd2;
          PCSrc         = 2'd3;
          IRWrite       = mem_ready;
          PCWrite       = mem_ready;
        end
        S_DEC: begin
          ALUSrcY       = 2'd3;
          FunctionClass = 2'd2;
        end
        S_MADDR: begin
          ALUSrcX       = 1'b1;
          ALUSrcY       = 2'd2;
          FunctionClass = 2'd2;
        end
        S_MRD: begin
          InstData = 1'b1;
          MemRead  = 1'b1;
        end
        S_MWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MWR: begin
          InstData   = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_AEX: begin
          ALUSrcX = 1'b1;
          ALUSrcY = r_type ? 2'd1 : 2'd2;
          FunctionClass = 2'd2;
          if (r_type) begin
            case (fn)
              6'h22: AddSub = 1'b1;
              6'h2A: begin
                FunctionClass = 2'd1;
                AddSub        = 1'b1;
              end
              6'h24, 6'h25, 6'h26, 6'h27: begin
                FunctionClass = 2'd3;
                LogFunc       = fn[1:0];
              end
              default: ;
            endcase
          end else begin
            case (op)
              6'h0A: begin
                FunctionClass = 2'd1;
                AddSub        = 1'b1;
              end
              6'h0C, 6'h0D, 6'h0E: begin
                FunctionClass = 2'd3;
                LogFunc       = op[1:0];
              end
              6'h0F: FunctionClass = 2'd0;
              default: ;
            endcase
          end
        end
        S_AWB: begin
          RegDst     = r_type ? 2'd1 : 2'd0;
          RegInSrc   = 2'd1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BR: begin
          ALUSrcX       = 1'b1;
          ALUSrcY       = 2'd1;
          FunctionClass = 2'd2;
          AddSub        = 1'b1;
          PCSrc         = 2'd2;
          PCWrite       = taken;
          instr_done    = 1'b1;
        end
        S_JMP: begin
          JumpAddr   = 1'b1;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          if (op == 6'h03) begin
            RegDst   = 2'd2;
            RegInSrc = 2'd2;
            RegWrite = 1'b1;
          end
        end
        S_JR: begin
          PCSrc      = 2'd1;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          JumpAddr   = SYSCALL_SEL;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm.
// Instruction-level reference model tracks the expected state walk.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, fn;
  logic       alu_zero, x_sign, mem_ready;
  logic       PCWrite, InstData, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, RegInSrc, ALUSrcY, FunctionClass, LogFunc, PCSrc;
  logic       ALUSrcX, AddSub, JumpAddr, instr_done;
  logic [3:0] state;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .fn(fn),
    .alu_zero(alu_zero), .x_sign(x_sign), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .InstData(InstData), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .RegInSrc(RegInSrc), .ALUSrcX(ALUSrcX),
    .ALUSrcY(ALUSrcY), .FunctionClass(FunctionClass),
    .LogFunc(LogFunc), .AddSub(AddSub), .PCSrc(PCSrc),
    .JumpAddr(JumpAddr), .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  localparam int K_LW = 0, K_SW = 1, K_BEQ = 2, K_BNE = 3, K_BLTZ = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_TRAP = 8;
  localparam int K_ALUR = 9, K_ALUI = 10;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [1:0] ysel;
    logic [1:0] cls;
    logic [1:0] lf;
    logic       sub;
  } ins_t;

  ins_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {PCWrite, MemRead, MemWrite, IRWrite, RegWrite, instr_done};
  endfunction

  function automatic logic [20:0] selects();
    return {InstData, RegDst, RegInSrc, ALUSrcX, ALUSrcY, FunctionClass,
            LogFunc, AddSub, PCSrc, JumpAddr, 4'd0};
  endfunction

  initial begin
    ins_t cur;
    int   route[$];
    int   idx;
    int   es;
    bit   wt, last, tk, pcw, rgw;

    tbl.push_back('{6'h00, 6'h20, K_ALUR, 2'd1, 2'd2, 2'd0, 1'b0});
    tbl.push_back('{6'h00, 6'h22, K_ALUR, 2'd1, 2'd2, 2'd0, 1'b1});
    tbl.push_back('{6'h00, 6'h24, K_ALUR, 2'd1, 2'd3, 2'd0, 1'b0});
    tbl.push_back('{6'h00, 6'h25, K_ALUR, 2'd1, 2'd3, 2'd1, 1'b0});
    tbl.push_back('{6'h00, 6'h26, K_ALUR, 2'd1, 2'd3, 2'd2, 1'b0});
    tbl.push_back('{6'h00, 6'h27, K_ALUR, 2'd1, 2'd3, 2'd3, 1'b0});
    tbl.push_back('{6'h00, 6'h2A, K_ALUR, 2'd1, 2'd1, 2'd0, 1'b1});
    tbl.push_back('{6'h08, 6'h00, K_ALUI, 2'd2, 2'd2, 2'd0, 1'b0});
    tbl.push_back('{6'h0A, 6'h00, K_ALUI, 2'd2, 2'd1, 2'd0, 1'b1});
    tbl.push_back('{6'h0C, 6'h00, K_ALUI, 2'd2, 2'd3, 2'd0, 1'b0});
    tbl.push_back('{6'h0D, 6'h00, K_ALUI, 2'd2, 2'd3, 2'd1, 1'b0});
    tbl.push_back('{6'h0E, 6'h00, K_ALUI, 2'd2, 2'd3, 2'd2, 1'b0});
    tbl.push_back('{6'h0F, 6'h00, K_ALUI, 2'd2, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h23, 6'h00, K_LW,   2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h2B, 6'h00, K_SW,   2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h04, 6'h00, K_BEQ,  2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h05, 6'h00, K_BNE,  2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h01, 6'h00, K_BLTZ, 2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h02, 6'h00, K_J,    2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h03, 6'h00, K_JAL,  2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h00, 6'h08, K_JR,   2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h00, 6'h0C, K_TRAP, 2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h3F, 6'h00, K_TRAP, 2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h10, 6'h00, K_TRAP, 2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h00, 6'h01, K_TRAP, 2'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{6'h00, 6'h21, K_TRAP, 2'd0, 2'd0, 2'd0, 1'b0});

    // Reset: everything quiet, state at FETCH.
    reset = 1'b1; op = 6'h23; fn = 6'h00;
    alu_zero = 1'b1; x_sign = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_selects", 32'(selects()), 32'd0);

    // Store held off by memory, then reset lands inside MEM_WRITE.
    @(negedge clk);
    reset = 1'b0; op = 6'h2B; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (state == 4'd6) break;
      @(negedge clk);
    end
    #1;
    chk("sw_reach_mw", 32'(state), 32'd6);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_done_wait", 32'(instr_done), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_strobes", 32'(strobes()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_memread", 32'(MemRead), 32'd1);

    // Random instruction stream against the reference walk.
    idx = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (idx == route.size()) begin
        cur = tbl[$urandom_range(0, tbl.size() - 1)];
        op  = cur.op;
        fn  = (cur.op == 6'h00) ? cur.fn : 6'($urandom);
        route = '{0, 1};
        case (cur.kind)
          K_LW:                  route = '{0, 1, 2, 3, 4};
          K_SW:                  route = '{0, 1, 2, 6};
          K_BEQ, K_BNE, K_BLTZ:  route = '{0, 1, 5};
          K_J, K_JAL:            route = '{0, 1, 9};
          K_JR:                  route = '{0, 1, 10};
          K_TRAP:                route = '{0, 1, 11};
          default:               route = '{0, 1, 7, 8};
        endcase
        idx = 0;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      alu_zero  = 1'($urandom);
      x_sign    = 1'($urandom);
      #1;
      es   = route[idx];
      wt   = (es == 0 || es == 3 || es == 6) && !mem_ready;
      last = (idx == route.size() - 1) && !wt;
      tk   = (cur.kind == K_BEQ && alu_zero) ||
             (cur.kind == K_BNE && !alu_zero) ||
             (cur.kind == K_BLTZ && x_sign);
      pcw  = (es == 0 && mem_ready) || (es == 5 && tk) ||
             es == 9 || es == 10 || es == 11;
      rgw  = es == 4 || es == 8 || (es == 9 && cur.kind == K_JAL);
      chk("state", 32'(state), 32'(es));
      chk("strobes", 32'(strobes()),
          32'({pcw, es == 0 || es == 3, es == 6,
               es == 0 && mem_ready, rgw, last}));
      case (es)
        0: chk("fetch_sel",
               32'({InstData, ALUSrcX, ALUSrcY, FunctionClass, AddSub, PCSrc}),
               32'({1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd3}));
        1: chk("dec_sel", 32'({ALUSrcX, ALUSrcY, AddSub}),
               32'({1'b0, 2'd3, 1'b0}));
        2: chk("maddr_sel",
               32'({ALUSrcX, ALUSrcY, FunctionClass, AddSub}),
               32'({1'b1, 2'd2, 2'd2, 1'b0}));
        3, 6: chk("mem_instdata", 32'(InstData), 32'd1);
        4: chk("mwb_sel", 32'({RegDst, RegInSrc}), 32'd0);
        5: chk("br_sel",
               32'({ALUSrcX, ALUSrcY, FunctionClass, AddSub, PCSrc}),
               32'({1'b1, 2'd1, 2'd2, 1'b1, 2'd2}));
        7: chk("alu_sel",
               32'({ALUSrcX, ALUSrcY, FunctionClass, LogFunc, AddSub}),
               32'({1'b1, cur.ysel, cur.cls, cur.lf, cur.sub}));
        8: chk("awb_sel", 32'({RegDst, RegInSrc}),
               32'({(cur.kind == K_ALUR) ? 2'd1 : 2'd0, 2'd1}));
        9: chk("jmp_sel", 32'({PCSrc, JumpAddr, RegDst, RegInSrc}),
               32'({2'd0, 1'b1,
                    (cur.kind == K_JAL) ? 4'b1010 : 4'b0000}));
        10: chk("jr_sel", 32'(PCSrc), 32'd1);
        11: chk("trap_sel", 32'({PCSrc, JumpAddr}), 32'd0);
        default: ;
      endcase
      if (!wt) idx++;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
